// File: rtl/register.sv
// Two-byte display register fed by a byte receiver, with an error state.
// Define REGISTER_ERR_STICKY_EN to make the error state sticky until reset.
module register #(
   parameter logic [15:0] ERR_CODE = 16'hEEEE
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  data_in,
   input  logic        valid,
   input  logic        PERROR,
   input  logic        FERROR,
   output logic [15:0] out
);

   localparam logic [1:0] S_EMPTY = 2'd0;
   localparam logic [1:0] S_ONE   = 2'd1;
   localparam logic [1:0] S_TWO   = 2'd2;
   localparam logic [1:0] S_ERR   = 2'd3;

   logic [1:0]  state_q, state_d;
   logic [15:0] out_q, out_d;
   logic        valid_q;
   logic        accept;
   logic        err;
   logic        err_exit;

   assign accept = valid & ~valid_q;
   assign err    = PERROR | FERROR;

`ifdef REGISTER_ERR_STICKY_EN
   assign err_exit = 1'b0;
`else
   assign err_exit = 1'b1;
`endif

   // Errors take priority over a same-edge accept; the byte is dropped.
   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      if (err) begin
         state_d = S_ERR;
         out_d   = ERR_CODE;
      end else if (accept) begin
         case (state_q)
            S_EMPTY: begin
               state_d = S_ONE;
               out_d   = {8'h00, data_in};
            end
            S_ONE, S_TWO: begin
               state_d = S_TWO;
               out_d   = {out_q[7:0], data_in};
            end
            S_ERR: begin
               if (err_exit) begin
                  state_d = S_ONE;
                  out_d   = {8'h00, data_in};
               end
            end
            default: begin
               state_d = S_EMPTY;
               out_d   = 16'h0000;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_EMPTY;
         out_q   <= 16'h0000;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         valid_q <= valid;
      end
   end

   assign out = out_q;

endmodule

// File: tb/tb_register.sv
// Bench for register: directed vector table, reset corner cases,
// and random stimulus against a byte-history reference model.
module tb_register;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  data_in;
   logic        valid;
   logic        PERROR;
   logic        FERROR;
   logic [15:0] out;

   int nchk = 0;
   int nerr = 0;

`ifdef REGISTER_ERR_STICKY_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif
   localparam logic [15:0] EC = 16'hEEEE;

   always #5 clk = ~clk;

   register #(.ERR_CODE(EC)) dut (
      .clk(clk),
      .reset(reset),
      .data_in(data_in),
      .valid(valid),
      .PERROR(PERROR),
      .FERROR(FERROR),
      .out(out)
   );

   // Reference model: bytes accepted since the last error/reset.
   logic [7:0] hist[$];
   bit         merr;
   bit         mprev_v;

   function automatic logic [15:0] mexp();
      logic [15:0] r;
      r = 16'h0000;
      if (merr) r = EC;
      else begin
         if (hist.size() >= 1) r[7:0] = hist[hist.size()-1];
         if (hist.size() >= 2) r[15:8] = hist[hist.size()-2];
      end
      return r;
   endfunction

   task automatic mreset();
      hist.delete();
      merr = 1'b0;
      mprev_v = 1'b0;
   endtask

   task automatic chk(input string name, input logic [15:0] exp);
      nchk++;
      if (out !== exp) begin
         nerr++;
         $display("FAIL %s: out=%h expected=%h", name, out, exp);
      end
   endtask

   // Called at a falling edge; drives inputs and advances one cycle.
   task automatic step(input logic v, input logic [7:0] d,
                       input logic pe, input logic fe);
      bit acc;
      valid = v;
      data_in = d;
      PERROR = pe;
      FERROR = fe;
      acc = v && !mprev_v;
      mprev_v = v;
      if (pe || fe) begin
         merr = 1'b1;
         hist.delete();
      end else if (acc && !(merr && STICKY)) begin
         merr = 1'b0;
         hist.push_back(d);
         if (hist.size() > 2) void'(hist.pop_front());
      end
      @(negedge clk);
   endtask

   // Assert reset mid high phase, check without waiting for an edge.
   task automatic async_reset(input string name);
      @(posedge clk);
      #2;
      reset = 1'b0;
      valid = 1'($urandom);
      data_in = 8'($urandom);
      PERROR = 1'($urandom);
      FERROR = 1'($urandom);
      mreset();
      #1;
      chk(name, 16'h0000);
      @(negedge clk);
      @(negedge clk);
      chk({name, "_held"}, 16'h0000);
      reset = 1'b1;
   endtask

   typedef struct {
      string       name;
      logic        v;
      logic [7:0]  d;
      logic        pe;
      logic        fe;
      logic [15:0] exp;
   } vec_t;

   vec_t tbl[$];

   initial begin
      tbl.push_back('{"idle",       1'b0, 8'hE3, 1'b0, 1'b0, 16'h0000});
      tbl.push_back('{"acc_e3",     1'b1, 8'hE3, 1'b0, 1'b0, 16'h00E3});
      tbl.push_back('{"drop_v",     1'b0, 8'hFF, 1'b0, 1'b0, 16'h00E3});
      tbl.push_back('{"acc_ff",     1'b1, 8'hFF, 1'b0, 1'b0, 16'hE3FF});
      tbl.push_back('{"drop_v2",    1'b0, 8'h00, 1'b0, 1'b0, 16'hE3FF});
      tbl.push_back('{"hold_v1",    1'b1, 8'h00, 1'b0, 1'b0, 16'hFF00});
      tbl.push_back('{"hold_v2",    1'b1, 8'h00, 1'b0, 1'b0, 16'hFF00});
      tbl.push_back('{"hold_v3",    1'b1, 8'h00, 1'b0, 1'b0, 16'hFF00});
      tbl.push_back('{"hold_v4",    1'b1, 8'h5A, 1'b0, 1'b0, 16'hFF00});
      tbl.push_back('{"hold_v5",    1'b1, 8'hA5, 1'b0, 1'b0, 16'hFF00});
      tbl.push_back('{"idle2",      1'b0, 8'h33, 1'b0, 1'b0, 16'hFF00});
      tbl.push_back('{"perr",       1'b0, 8'h00, 1'b1, 1'b0, EC});
      tbl.push_back('{"err_hold",   1'b0, 8'h4D, 1'b0, 1'b0, EC});
      tbl.push_back('{"err_acc",    1'b1, 8'h4D, 1'b0, 1'b0,
                      STICKY ? EC : 16'h004D});
      tbl.push_back('{"err_acc2",   1'b0, 8'h00, 1'b0, 1'b0,
                      STICKY ? EC : 16'h004D});
      tbl.push_back('{"ferr_acc",   1'b1, 8'h55, 1'b0, 1'b1, EC});
      tbl.push_back('{"ferr_low",   1'b0, 8'h55, 1'b0, 1'b1, EC});
      tbl.push_back('{"err_ign",    1'b1, 8'hAA, 1'b1, 1'b0, EC});
      tbl.push_back('{"no_rise",    1'b1, 8'hAA, 1'b0, 1'b0, EC});
      tbl.push_back('{"after",      1'b0, 8'h00, 1'b0, 1'b0, EC});

      reset = 1'b0;
      valid = 1'b0;
      data_in = 8'h00;
      PERROR = 1'b0;
      FERROR = 1'b0;
      mreset();
      #1;
      chk("reset_imm", 16'h0000);
      @(negedge clk);
      @(negedge clk);
      chk("reset_init", 16'h0000);
      reset = 1'b1;

      foreach (tbl[i]) begin
         step(tbl[i].v, tbl[i].d, tbl[i].pe, tbl[i].fe);
         chk(tbl[i].name, tbl[i].exp);
      end

      // Reset while holding E3FF, then accept 12 on the first edge.
      async_reset("rst_e3ff_pre");
      step(1'b0, 8'h00, 1'b0, 1'b0);
      step(1'b1, 8'hE3, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      step(1'b1, 8'hFF, 1'b0, 1'b0);
      chk("e3ff", 16'hE3FF);
      async_reset("rst_e3ff");
      step(1'b1, 8'h12, 1'b0, 1'b0);
      chk("first_edge_acc", 16'h0012);

      // Reset while in error.
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("err_before_rst", EC);
      async_reset("rst_err");
      step(1'b0, 8'h77, 1'b0, 1'b0);
      chk("rst_err_after", 16'h0000);
      step(1'b1, 8'h77, 1'b0, 1'b0);
      chk("rst_err_acc", 16'h0077);

      for (int i = 0; i < 600; i++) begin
         logic v, pe, fe;
         logic [7:0] d;
         if ($urandom_range(0, 79) == 0) begin
            async_reset("rnd_rst");
         end
         v  = ($urandom_range(0, 2) != 0);
         d  = 8'($urandom);
         pe = ($urandom_range(0, 19) == 0);
         fe = ($urandom_range(0, 19) == 0);
         step(v, d, pe, fe);
         chk("random", mexp());
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
